// File: rtl/pipeline_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_if
// Bundles the signals exchanged between the pipeline sequencer and the
// datapath of the 5-stage cpu. The sequencer takes the slave modport and the
// datapath (or a testbench) takes the master modport.
//
// Signals driven by the datapath (master -> slave):
//   id_rn, id_rd             register indices of the instruction in ID
//   id_uses_rn, id_uses_rd   ID instruction reads Rn / Rd
//   id_writes_rd             ID instruction writes Rd
//   ex_branch_taken          EX instruction is a taken branch
//   mem_busy                 memory stage has not finished this cycle
// Signals driven by the sequencer (slave -> master):
//   pc_en, pc_sel            PC load enable and select (1 = branch target)
//   if_en, id_en, ex_en, mem_en   stage latch enables
//   if_valid .. wb_valid     registered stage valid bits
//   wb_write, wb_rd          register-file write strobe and index
//   stall, flush             status of the current cycle
//   stall_count, flush_count saturating hazard counters for the debug port
// ---------------------------------------------------------------------------
interface pipeline_ctrl_if #(
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 16
);
    logic [REG_ADDR_W-1:0] id_rn;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_uses_rn;
    logic                  id_uses_rd;
    logic                  id_writes_rd;
    logic                  ex_branch_taken;
    logic                  mem_busy;

    logic                  pc_en;
    logic                  pc_sel;
    logic                  if_en;
    logic                  id_en;
    logic                  ex_en;
    logic                  mem_en;
    logic                  if_valid;
    logic                  id_valid;
    logic                  ex_valid;
    logic                  mem_valid;
    logic                  wb_valid;
    logic                  wb_write;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic                  stall;
    logic                  flush;
    logic [CNT_W-1:0]      stall_count;
    logic [CNT_W-1:0]      flush_count;

    modport master (
        output id_rn, id_rd, id_uses_rn, id_uses_rd, id_writes_rd,
               ex_branch_taken, mem_busy,
        input  pc_en, pc_sel, if_en, id_en, ex_en, mem_en,
               if_valid, id_valid, ex_valid, mem_valid, wb_valid,
               wb_write, wb_rd, stall, flush, stall_count, flush_count
    );

    modport slave (
        input  id_rn, id_rd, id_uses_rn, id_uses_rd, id_writes_rd,
               ex_branch_taken, mem_busy,
        output pc_en, pc_sel, if_en, id_en, ex_en, mem_en,
               if_valid, id_valid, ex_valid, mem_valid, wb_valid,
               wb_write, wb_rd, stall, flush, stall_count, flush_count
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
// Central sequencer for the 5-stage cpu pipeline (IF, ID, EX, MEM, WB).
// Tracks one valid bit per stage and a per-register pending scoreboard,
// stalls ID on RAW/WAW hazards, flushes IF/ID on a taken branch in EX and
// freezes IF..MEM while memory is busy. No forwarding: a register stays
// pending until its producer has completed WB.
//
// Ports:
//   clk      clock, all state updates on the rising edge
//   nreset   asynchronous active-low reset
//   bus      pipeline_ctrl_if.slave, carrying ID register usage, branch and
//            memory status in, and stage enables, PC control, valid bits,
//            WB write strobe, stall/flush status and counters out
// ---------------------------------------------------------------------------
module pipeline_ctrl #(
    parameter int REG_COUNT  = 16,
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             nreset,
    pipeline_ctrl_if.slave   bus
);

    logic                  if_valid_q;
    logic                  id_valid_q;
    logic                  ex_valid_q;
    logic                  mem_valid_q;
    logic                  wb_valid_q;
    logic                  ex_write_q;
    logic [REG_ADDR_W-1:0] ex_rd_q;
    logic                  mem_write_q;
    logic [REG_ADDR_W-1:0] mem_rd_q;
    logic                  wb_write_q;
    logic [REG_ADDR_W-1:0] wb_rd_q;
    logic [REG_COUNT-1:0]  pend;
    logic [CNT_W-1:0]      stall_count_q;
    logic [CNT_W-1:0]      flush_count_q;

    logic hazard;
    logic flush_c;
    logic stall_c;
    logic issue;
    logic front_en;
    logic wb_write_c;

    // Hazard detection and cycle classification. A flush outranks a hazard
    // so that the squashed ID instruction never stalls or issues, and a busy
    // memory stage suppresses both so nothing is counted while frozen.
    always_comb begin
        hazard     = 1'b0;
        flush_c    = 1'b0;
        stall_c    = 1'b0;
        issue      = 1'b0;
        front_en   = 1'b0;
        wb_write_c = 1'b0;

        hazard = id_valid_q &
                 ((bus.id_uses_rn   & pend[bus.id_rn]) |
                  (bus.id_uses_rd   & pend[bus.id_rd]) |
                  (bus.id_writes_rd & pend[bus.id_rd]));
        flush_c    = ex_valid_q & bus.ex_branch_taken & ~bus.mem_busy;
        stall_c    = hazard & ~flush_c & ~bus.mem_busy;
        issue      = id_valid_q & ~hazard & ~flush_c & ~bus.mem_busy;
        front_en   = ~bus.mem_busy & (flush_c | ~hazard);
        wb_write_c = wb_valid_q & wb_write_q;
    end

    assign bus.pc_en       = front_en;
    assign bus.if_en       = front_en;
    assign bus.id_en       = front_en;
    assign bus.pc_sel      = flush_c;
    assign bus.ex_en       = ~bus.mem_busy;
    assign bus.mem_en      = ~bus.mem_busy;
    assign bus.stall       = stall_c;
    assign bus.flush       = flush_c;
    assign bus.wb_write    = wb_write_c;
    assign bus.wb_rd       = wb_rd_q;
    assign bus.if_valid    = if_valid_q;
    assign bus.id_valid    = id_valid_q;
    assign bus.ex_valid    = ex_valid_q;
    assign bus.mem_valid   = mem_valid_q;
    assign bus.wb_valid    = wb_valid_q;
    assign bus.stall_count = stall_count_q;
    assign bus.flush_count = flush_count_q;

    // Pipeline state: valid bits, destination tags travelling EX->MEM->WB,
    // the pending-register scoreboard and the debug counters. A busy memory
    // stage freezes IF..MEM and drops a bubble into WB; otherwise MEM and WB
    // always advance, and the front end is governed by flush/stall.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            if_valid_q    <= 1'b0;
            id_valid_q    <= 1'b0;
            ex_valid_q    <= 1'b0;
            mem_valid_q   <= 1'b0;
            wb_valid_q    <= 1'b0;
            ex_write_q    <= 1'b0;
            ex_rd_q       <= '0;
            mem_write_q   <= 1'b0;
            mem_rd_q      <= '0;
            wb_write_q    <= 1'b0;
            wb_rd_q       <= '0;
            pend          <= '0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            if (bus.mem_busy) begin
                wb_valid_q <= 1'b0;
            end else begin
                mem_valid_q <= ex_valid_q;
                mem_write_q <= ex_write_q;
                mem_rd_q    <= ex_rd_q;
                wb_valid_q  <= mem_valid_q;
                wb_write_q  <= mem_write_q;
                wb_rd_q     <= mem_rd_q;

                if (flush_c) begin
                    if_valid_q <= 1'b0;
                    id_valid_q <= 1'b0;
                    ex_valid_q <= 1'b0;
                    ex_write_q <= 1'b0;
                end else if (stall_c) begin
                    ex_valid_q <= 1'b0;
                    ex_write_q <= 1'b0;
                end else begin
                    if_valid_q <= 1'b1;
                    id_valid_q <= if_valid_q;
                    ex_valid_q <= issue;
                    ex_write_q <= issue & bus.id_writes_rd;
                    ex_rd_q    <= bus.id_rd;
                end
            end

            // The set is written after the clear so a same-register
            // collision leaves the register pending.
            if (wb_write_c) begin
                pend[wb_rd_q] <= 1'b0;
            end
            if (issue && bus.id_writes_rd) begin
                pend[bus.id_rd] <= 1'b1;
            end

            if (stall_c && (stall_count_q != {CNT_W{1'b1}})) begin
                stall_count_q <= stall_count_q + 1'b1;
            end
            if (flush_c && (flush_count_q != {CNT_W{1'b1}})) begin
                flush_count_q <= flush_count_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl
// Directed bench for pipeline_ctrl using a 4-bit counter width so that
// counter saturation is reachable in a short run. Inputs change 1 time unit
// after each rising edge; outputs are sampled 1 unit later still.
// ---------------------------------------------------------------------------
module tb_pipeline_ctrl;

    logic clk;
    logic nreset;
    int   checkCount;
    int   errorCount;

    pipeline_ctrl_if #(.REG_ADDR_W(4), .CNT_W(4)) bus ();

    pipeline_ctrl #(
        .REG_COUNT (16),
        .REG_ADDR_W(4),
        .CNT_W     (4)
    ) dut (
        .clk   (clk),
        .nreset(nreset),
        .bus   (bus.slave)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive the instruction currently in ID plus branch/memory status.
    task automatic applyStimulus(input logic [3:0] rn, input logic [3:0] rd,
                                 input logic uses_rn, input logic uses_rd,
                                 input logic writes_rd, input logic branch,
                                 input logic busy);
        bus.id_rn           = rn;
        bus.id_rd           = rd;
        bus.id_uses_rn      = uses_rn;
        bus.id_uses_rd      = uses_rd;
        bus.id_writes_rd    = writes_rd;
        bus.ex_branch_taken = branch;
        bus.mem_busy        = busy;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Compact check of all five valid bits, packed {if,id,ex,mem,wb}.
    task automatic checkValids(input string tag, input logic [4:0] expected);
        checkOutput(tag, {bus.if_valid, bus.id_valid, bus.ex_valid,
                          bus.mem_valid, bus.wb_valid}, expected);
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        nreset     = 1'b0;
        applyStimulus(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // ---------------- reset state and start-up ----------------
        repeat (2) nextCycle();
        checkValids("reset_valids", 5'b00000);
        checkOutput("reset_wb_write", bus.wb_write, 1'b0);
        checkOutput("reset_stall_count", bus.stall_count, 4'd0);
        nreset = 1'b1;
        #1;
        checkOutput("start_pc_en", bus.pc_en, 1'b1);
        checkOutput("start_pc_sel", bus.pc_sel, 1'b0);
        nextCycle();
        checkValids("start_cycle1", 5'b10000);
        nextCycle();
        checkValids("start_cycle2", 5'b11000);
        nextCycle();
        checkValids("start_cycle3", 5'b11100);

        // Build up some state: r4 writer, then a taken branch behind it.
        applyStimulus(4'd0, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("pre_flush", bus.flush, 1'b1);
        nextCycle();
        applyStimulus(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("pre_flush_count", bus.flush_count, 4'd1);
        checkOutput("pre_pend4", dut.pend[4], 1'b1);
        repeat (3) nextCycle();

        // Asynchronous reset pulse in the middle of a cycle.
        nreset = 1'b0;
        #1;
        checkValids("midreset_valids", 5'b00000);
        checkOutput("midreset_pend", dut.pend, 16'h0000);
        checkOutput("midreset_flush_count", bus.flush_count, 4'd0);
        checkOutput("midreset_wb_write", bus.wb_write, 1'b0);
        nreset = 1'b1;
        nextCycle();
        checkValids("rel_cycle1", 5'b10000);
        nextCycle();
        checkValids("rel_cycle2", 5'b11000);
        repeat (3) nextCycle();
        checkValids("steady", 5'b11111);

        // ---------------- RAW: r3 writer then r3 reader ----------------
        applyStimulus(4'd0, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("raw_producer_stall", bus.stall, 1'b0);
        nextCycle();
        applyStimulus(4'd3, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("raw_stall1", bus.stall, 1'b1);
        checkOutput("raw_stall1_pc_en", bus.pc_en, 1'b0);
        checkOutput("raw_stall1_id_en", bus.id_en, 1'b0);
        checkOutput("raw_stall1_ex_en", bus.ex_en, 1'b1);
        nextCycle();
        checkOutput("raw_stall2", bus.stall, 1'b1);
        checkOutput("raw_bubble_ex", bus.ex_valid, 1'b0);
        nextCycle();
        checkOutput("raw_stall3", bus.stall, 1'b1);
        checkOutput("raw_wb_write", bus.wb_write, 1'b1);
        checkOutput("raw_wb_rd", bus.wb_rd, 4'd3);
        checkOutput("raw_pend3_in_wb", dut.pend[3], 1'b1);
        nextCycle();
        checkOutput("raw_issue_stall", bus.stall, 1'b0);
        checkOutput("raw_stall_count", bus.stall_count, 4'd3);
        checkOutput("raw_pend3_cleared", dut.pend[3], 1'b0);
        nextCycle();
        applyStimulus(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("raw_issued_ex", bus.ex_valid, 1'b1);

        // ---------------- WAW: two r5 writers ----------------
        applyStimulus(4'd0, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        nextCycle();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'd0, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            checkOutput($sformatf("waw_stall%0d", i + 1), bus.stall, 1'b1);
            nextCycle();
        end
        checkOutput("waw_issue_stall", bus.stall, 1'b0);
        checkOutput("waw_stall_count", bus.stall_count, 4'd6);
        nextCycle();
        applyStimulus(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("waw_pend5_reset_by_second", dut.pend[5], 1'b1);
        repeat (3) nextCycle();
        checkOutput("waw_pend5_drained", dut.pend[5], 1'b0);

        // ---------------- independent writers ----------------
        applyStimulus(4'd0, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(4'd7, 4'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("indep_stall", bus.stall, 1'b0);
        nextCycle();
        applyStimulus(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("indep_stall_count", bus.stall_count, 4'd6);

        // ---------------- taken branch ----------------
        applyStimulus(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("br_flush", bus.flush, 1'b1);
        checkOutput("br_pc_sel", bus.pc_sel, 1'b1);
        checkOutput("br_pc_en", bus.pc_en, 1'b1);
        nextCycle();
        applyStimulus(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkValids("br_after", 5'b00011);
        checkOutput("br_flush_count", bus.flush_count, 4'd1);
        nextCycle();
        checkOutput("br_target_if", bus.if_valid, 1'b1);
        checkOutput("br_target_id", bus.id_valid, 1'b0);
        repeat (2) nextCycle();
        checkOutput("br_refill_ex", bus.ex_valid, 1'b1);

        // ---------------- branch plus hazard in one cycle ----------------
        applyStimulus(4'd0, 4'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(4'd9, 4'd10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("brhz_flush", bus.flush, 1'b1);
        checkOutput("brhz_stall", bus.stall, 1'b0);
        checkOutput("brhz_pc_en", bus.pc_en, 1'b1);
        nextCycle();
        applyStimulus(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("brhz_stall_count", bus.stall_count, 4'd6);
        checkOutput("brhz_flush_count", bus.flush_count, 4'd2);
        checkOutput("brhz_pend10", dut.pend[10], 1'b0);
        checkOutput("brhz_pend9", dut.pend[9], 1'b1);
        repeat (5) nextCycle();
        checkValids("brhz_refilled", 5'b11111);

        // ---------------- memory busy for two cycles ----------------
        applyStimulus(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("busy_enables", {bus.pc_en, bus.if_en, bus.id_en,
                                     bus.ex_en, bus.mem_en}, 5'b00000);
        nextCycle();
        applyStimulus(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkValids("busy_valids1", 5'b11110);
        checkOutput("busy_branch_no_flush", bus.flush, 1'b0);
        checkOutput("busy_branch_pc_sel", bus.pc_sel, 1'b0);
        nextCycle();
        applyStimulus(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkValids("busy_valids2", 5'b11110);
        checkOutput("busy_release_pc_en", bus.pc_en, 1'b1);
        nextCycle();
        checkValids("busy_resumed", 5'b11111);
        checkOutput("busy_flush_count", bus.flush_count, 4'd2);
        checkOutput("busy_stall_count", bus.stall_count, 4'd6);

        // ---------------- stall counter saturation ----------------
        nreset = 1'b0;
        #1;
        checkOutput("sat_reset_count", bus.stall_count, 4'd0);
        nreset = 1'b1;
        repeat (5) nextCycle();
        for (int k = 1; k <= 7; k++) begin
            applyStimulus(4'd0, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            nextCycle();
            for (int s = 0; s < 3; s++) begin
                applyStimulus(4'd3, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                nextCycle();
            end
            checkOutput($sformatf("sat_count_after_%0d", k), bus.stall_count,
                        (3 * k > 15) ? 32'd15 : 32'(3 * k));
            nextCycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
